// File: rtl/wfifo_wr_sched_pkg.sv
// Shared types and Gray-code helpers for the async FIFO write side.
// Helpers operate on 32-bit values; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } wr_state_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int unsigned i = 31; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/wfifo_wr_sched_if.sv
// Requester / memory-side bundle of the FIFO write scheduler.
interface wfifo_wr_sched_if #(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [ADDRSIZE:0]     wq2_rptr;

    logic [NREQ-1:0]       grant;
    logic                  winc;
    logic [ADDRSIZE-1:0]   waddr;
    logic [DSIZE-1:0]      wdata;
    logic [ADDRSIZE:0]     wptr;
    logic                  wfull;
    logic                  walmost_full;
    logic [ADDRSIZE:0]     wfree;

    modport master (
        output req, req_last, req_lock, req_data, wq2_rptr,
        input  grant, winc, waddr, wdata, wptr, wfull, walmost_full, wfree
    );

    modport slave (
        input  req, req_last, req_lock, req_data, wq2_rptr,
        output grant, winc, waddr, wdata, wptr, wfull, walmost_full, wfree
    );
endinterface

// File: rtl/wfifo_wr_sched_arb.sv
// Round-robin arbiter with lock override: a locked owner is the only candidate.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    input  logic            lock_en,
    input  logic [IW-1:0]   owner,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (lock_en) begin
            grant[owner] = req[owner];
            grant_idx    = owner;
        end else begin
            // Search upward from rr_ptr with wrap; first hit wins.
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(rr_ptr) + k) % NREQ;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/wfifo_wr_sched.sv
// Write-side scheduler: arbitrates requesters onto the FIFO write port and
// owns the write pointer plus full / almost-full / free-count flags.
module wfifo_wr_sched
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int AFULL_TH = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    wfifo_wr_sched_if.slave  bus
);

    localparam int                IW    = $clog2(NREQ);
    localparam logic [ADDRSIZE:0] DEPTH = (ADDRSIZE+1)'(1 << ADDRSIZE);

    wr_state_t           state, state_next;
    logic [IW-1:0]       rr_ptr, owner, grant_idx;
    logic [NREQ-1:0]     req_eff, grant;
    logic                winc;
    logic [ADDRSIZE:0]   wbin, wbin_next, wgray_next, rbin, wfree_next;
    logic                wfull_next;
    logic [ADDRSIZE:0]   wptr_q, wfree_q;
    logic                wfull_q, walmost_full_q;

    // Requests are masked while full and while reset is held.
    assign req_eff = (wrst_n && !wfull_q) ? bus.req : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_eff),
        .rr_ptr    (rr_ptr),
        .lock_en   (state == LOCKED),
        .owner     (owner),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign winc             = |grant;
    assign bus.grant        = grant;
    assign bus.winc         = winc;
    assign bus.waddr        = wbin[ADDRSIZE-1:0];
    assign bus.wdata        = bus.req_data[grant_idx*DSIZE +: DSIZE];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wfree        = wfree_q;

    always_comb begin
        wbin_next  = wbin + (ADDRSIZE+1)'(winc);
        wgray_next = (ADDRSIZE+1)'(bin2gray(32'(wbin_next)));
        rbin       = (ADDRSIZE+1)'(gray2bin(32'(bus.wq2_rptr)));
        wfree_next = DEPTH - (wbin_next - rbin);
        wfull_next = (wgray_next == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                      bus.wq2_rptr[ADDRSIZE-2:0]});
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (winc && bus.req_lock[grant_idx] && !bus.req_last[grant_idx])
                    state_next = LOCKED;
            LOCKED:
                if (winc && bus.req_last[owner])
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin           <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            wfree_q        <= DEPTH;
            walmost_full_q <= (32'(DEPTH) <= AFULL_TH);
            rr_ptr         <= '0;
            owner          <= '0;
        end else begin
            wbin           <= wbin_next;
            wptr_q         <= wgray_next;
            wfull_q        <= wfull_next;
            wfree_q        <= wfree_next;
            walmost_full_q <= (32'(wfree_next) <= AFULL_TH);
            if (winc)
                rr_ptr <= IW'((32'(grant_idx) + 1) % NREQ);
            if (state == IDLE && state_next == LOCKED)
                owner <= grant_idx;
        end
    end

endmodule
